// File: rtl/fwft_lane_reader.sv
// fwft_lane_reader
// Pops one wide word at a time from a first-word-fall-through FIFO and replays
// it as IN_WIDTH/OUT_WIDTH narrow lanes on a valid/ready stream. The next word
// is popped on the same edge that retires the last lane, so a non-empty FIFO
// streams one lane per cycle with no bubble at word boundaries.
//
// DELAY is kept so existing instantiations still elaborate. This block has no
// #delay on its registered assignments, so DELAY has no effect beyond the
// parameter sanity check below.
module fwft_lane_reader #(
    parameter int DELAY     = 1,
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 RD_CLK,
    input  logic                 RESET,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_rden,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [31:0]          words_popped
);

    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    // Reject illegal widths at elaboration rather than building a broken lane mux
    if ((IN_WIDTH % OUT_WIDTH) != 0 || LANES < 2 || DELAY < 0) begin : g_bad_params
        $error("fwft_lane_reader: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 lanes, DELAY >= 0");
    end

    logic [IN_WIDTH-1:0] word_reg_q, word_reg_d;
    logic                word_valid_q, word_valid_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [31:0]         words_popped_q, words_popped_d;
    logic                xfer;

    assign out_valid    = word_valid_q;
    assign out_last     = word_valid_q && (lane_q == LAST_LANE);
    assign xfer         = word_valid_q && out_ready;
    assign words_popped = words_popped_q;

    // Pop when nothing is held, or when the last lane leaves this cycle.
    // RESET and flush both block the pop so no FIFO word is lost.
    assign fifo_rden = !RESET && !flush && !fifo_empty && (!word_valid_q || (xfer && out_last));

    // Select the current lane from the held word; lane order flips with MSB_FIRST
    always_comb begin
        out_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) begin
                out_data = word_reg_q[(MSB_FIRST ? (LANES - 1 - k) : k) * OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Next-state for the held word: flush, then pop, then lane retire/advance
    always_comb begin
        word_reg_d     = word_reg_q;
        word_valid_d   = word_valid_q;
        lane_d         = lane_q;
        words_popped_d = words_popped_q;
        if (flush) begin
            word_valid_d = 1'b0;
            lane_d       = '0;
        end else if (fifo_rden) begin
            word_reg_d     = fifo_dout;
            word_valid_d   = 1'b1;
            lane_d         = '0;
            words_popped_d = words_popped_q + 32'd1;
        end else if (xfer && out_last) begin
            word_valid_d = 1'b0;
            lane_d       = '0;
        end else if (xfer) begin
            lane_d = lane_q + LW'(1);
        end
    end

    // State registers with synchronous reset; a word held at reset is dropped
    always_ff @(posedge RD_CLK) begin
        if (RESET) begin
            word_reg_q     <= '0;
            word_valid_q   <= 1'b0;
            lane_q         <= '0;
            words_popped_q <= '0;
        end else begin
            word_reg_q     <= word_reg_d;
            word_valid_q   <= word_valid_d;
            lane_q         <= lane_d;
            words_popped_q <= words_popped_d;
        end
    end

endmodule
